// File: rtl/data_memory_access_unit_pkg.sv
// data_mem_pkg: shared definitions for the data memory access unit.
//   - Access size encodings carried on req_size.
//   - FSM state encoding of the unit.
//   - Default byte address mapped onto memory word 0.
//   - Bus data/address width constant used by the interface.
package data_mem_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h1001_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_MERGE = 3'd2,
    ST_WRITE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

endpackage

// File: rtl/data_memory_access_unit_if.sv
// data_memory_access_unit_if: request/response and memory-side signals of the
// data memory access unit.
//   master : requester plus memory environment (drives req_*, mem_read_data)
//   slave  : the access unit (drives req_ready, resp_*, mem_* strobes/address/data)
interface data_memory_access_unit_if;
  import data_mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [DATA_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_error;
  logic [DATA_W-1:0] resp_rdata;
  logic              mem_write_enable;
  logic [DATA_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  modport master (
    output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    output mem_read_data,
    input  req_ready, resp_valid, resp_error, resp_rdata,
    input  mem_write_enable, mem_address, mem_write_data
  );

  modport slave (
    input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
    input  mem_read_data,
    output req_ready, resp_valid, resp_error, resp_rdata,
    output mem_write_enable, mem_address, mem_write_data
  );

endinterface

// File: rtl/data_memory_access_unit_byte_lane_align.sv
// byte_lane_align: combinational little-endian lane steering.
//   word      in  32  memory word as read
//   wdata     in  32  store data, right-aligned
//   offset    in  2   byte offset within the word
//   size      in  2   access size encoding
//   is_signed in  1   sign-extend loads when set
//   extracted out 32  load result (extended lane)
//   merged    out 32  word with the addressed lane replaced by wdata
module byte_lane_align
  import data_mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_signed,
  output logic [31:0] extracted,
  output logic [31:0] merged
);

  logic [4:0]  byte_shamt_s;
  logic [4:0]  half_shamt_s;
  logic [7:0]  byte_lane_s;
  logic [15:0] half_lane_s;

  // Lane selection and extension for loads, lane replacement for stores.
  always_comb begin
    byte_shamt_s = {offset, 3'b000};
    half_shamt_s = {offset[1], 4'b0000};
    byte_lane_s  = word[byte_shamt_s +: 8];
    half_lane_s  = word[half_shamt_s +: 16];
    extracted    = 32'h0000_0000;
    merged       = word;
    case (size)
      SIZE_BYTE: begin
        extracted = {{24{is_signed & byte_lane_s[7]}}, byte_lane_s};
        merged    = (word & ~(32'h0000_00FF << byte_shamt_s))
                  | ({24'h00_0000, wdata[7:0]} << byte_shamt_s);
      end
      SIZE_HALF: begin
        extracted = {{16{is_signed & half_lane_s[15]}}, half_lane_s};
        merged    = (word & ~(32'h0000_FFFF << half_shamt_s))
                  | ({16'h0000, wdata[15:0]} << half_shamt_s);
      end
      SIZE_WORD: begin
        extracted = word;
        merged    = wdata;
      end
      default: begin
        extracted = 32'h0000_0000;
        merged    = word;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_access_unit.sv
// data_memory_access_unit: initiator-side controller for a word-wide memory with
// one-cycle synchronous read. One load/store in flight; sub-word stores use
// read-modify-write; loads return sign/zero-extended data.
//   clk   in  1  rising-edge clock
//   reset in  1  synchronous, active-low reset
//   bus   slave modport of data_memory_access_unit_if (request, response, memory)
module data_memory_access_unit
  import data_mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 64,
  parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
  input logic                      clk,
  input logic                      reset,
  data_memory_access_unit_if.slave bus
);

  state_t                  state_r;
  logic                    req_ready_r;
  logic                    write_r;
  logic [1:0]              size_r;
  logic                    signed_r;
  logic [1:0]              offset_r;
  logic [DATA_WIDTH-1:0]   wdata_r;
  logic                    resp_valid_r;
  logic                    resp_error_r;
  logic [DATA_WIDTH-1:0]   resp_rdata_r;
  logic                    mem_we_r;
  logic [DATA_WIDTH-1:0]   mem_addr_r;
  logic [DATA_WIDTH-1:0]   mem_wdata_r;

  logic [31:0]             rel_addr_s;
  logic [31:0]             word_index_s;
  logic                    error_s;
  logic [31:0]             extracted_s;
  logic [31:0]             merged_s;

  // Request checks; wrap-around below the base is caught by the explicit compare.
  always_comb begin
    rel_addr_s   = bus.req_addr - BASE_ADDRESS;
    word_index_s = rel_addr_s >> 5'd2;
    error_s      = 1'b0;
    if (bus.req_addr < BASE_ADDRESS) begin
      error_s = 1'b1;
    end else if (word_index_s >= MEMORY_DEPTH) begin
      error_s = 1'b1;
    end else begin
      case (bus.req_size)
        SIZE_BYTE: error_s = 1'b0;
        SIZE_HALF: error_s = bus.req_addr[0];
        SIZE_WORD: error_s = (bus.req_addr[1:0] != 2'b00);
        default:   error_s = 1'b1;
      endcase
    end
  end

  byte_lane_align u_align (
    .word      (bus.mem_read_data),
    .wdata     (wdata_r),
    .offset    (offset_r),
    .size      (size_r),
    .is_signed (signed_r),
    .extracted (extracted_s),
    .merged    (merged_s)
  );

  // Control FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      req_ready_r  <= 1'b1;
      write_r      <= 1'b0;
      size_r       <= 2'b00;
      signed_r     <= 1'b0;
      offset_r     <= 2'b00;
      wdata_r      <= '0;
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      resp_rdata_r <= '0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wdata_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.req_valid && req_ready_r) begin
            write_r     <= bus.req_write;
            size_r      <= bus.req_size;
            signed_r    <= bus.req_signed;
            offset_r    <= bus.req_addr[1:0];
            wdata_r     <= bus.req_wdata;
            req_ready_r <= 1'b0;
            if (error_s) begin
              state_r      <= ST_RESP;
              resp_valid_r <= 1'b1;
              resp_error_r <= 1'b1;
              resp_rdata_r <= '0;
            end else if (bus.req_write && (bus.req_size == SIZE_WORD)) begin
              // Full-word store needs no read.
              state_r     <= ST_WRITE;
              mem_addr_r  <= word_index_s;
              mem_wdata_r <= bus.req_wdata;
              mem_we_r    <= 1'b1;
            end else begin
              state_r    <= ST_READ;
              mem_addr_r <= word_index_s;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_READ: begin
          state_r <= ST_MERGE;
        end
        ST_MERGE: begin
          if (write_r) begin
            state_r     <= ST_WRITE;
            mem_wdata_r <= merged_s;
            mem_we_r    <= 1'b1;
          end else begin
            state_r      <= ST_RESP;
            resp_valid_r <= 1'b1;
            resp_error_r <= 1'b0;
            resp_rdata_r <= extracted_s;
            mem_addr_r   <= '0;
          end
        end
        ST_WRITE: begin
          state_r      <= ST_RESP;
          mem_we_r     <= 1'b0;
          mem_wdata_r  <= '0;
          mem_addr_r   <= '0;
          resp_valid_r <= 1'b1;
          resp_error_r <= 1'b0;
          resp_rdata_r <= '0;
        end
        ST_RESP: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_error_r <= 1'b0;
          resp_rdata_r <= '0;
        end
        default: begin
          state_r      <= ST_IDLE;
          req_ready_r  <= 1'b1;
          resp_valid_r <= 1'b0;
          resp_error_r <= 1'b0;
          resp_rdata_r <= '0;
          mem_we_r     <= 1'b0;
          mem_addr_r   <= '0;
          mem_wdata_r  <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready        = req_ready_r;
  assign bus.resp_valid       = resp_valid_r;
  assign bus.resp_error       = resp_error_r;
  assign bus.resp_rdata       = resp_rdata_r;
  // Gating by reset keeps a write from committing on a reset edge mid-operation.
  assign bus.mem_write_enable = mem_we_r & reset;
  assign bus.mem_address      = mem_addr_r;
  assign bus.mem_write_data   = mem_wdata_r;

endmodule

// File: tb/tb_data_memory_access_unit.sv
// Testbench for data_memory_access_unit: directed scenarios plus randomized
// traffic, checked against a word-array reference model of the memory and the
// load/store rules, with a 1-cycle synchronous-read memory model attached.
module tb_data_memory_access_unit;

  localparam logic [31:0] BASE = 32'h1001_0000;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  int   n_req;
  int   accepts;

  logic [31:0] mem_dev [64];
  logic [31:0] ref_mem [64];

  data_memory_access_unit_if bus ();

  data_memory_access_unit #(
    .DATA_WIDTH   (32),
    .MEMORY_DEPTH (64),
    .BASE_ADDRESS (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Synchronous-read memory attached to the unit.
  always @(posedge clk) begin
    if (bus.mem_write_enable) mem_dev[bus.mem_address[5:0]] <= bus.mem_write_data;
    bus.mem_read_data <= mem_dev[bus.mem_address[5:0]];
  end

  // Count handshakes to prove each request is accepted once.
  always @(posedge clk) begin
    if (reset && bus.req_valid && bus.req_ready) accepts <= accepts + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: outcome of one request from the access rules, updating ref_mem.
  function automatic void model(input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output logic err, output logic [31:0] rd, output int lat,
                                output int nwr, output logic [31:0] idx,
                                output logic [31:0] nword);
    int k;
    logic [31:0] w, lane, mask;
    err = 1'b0; rd = 32'd0; nwr = 0; nword = 32'd0; idx = 32'd0; lat = 1;
    if (addr < BASE) err = 1'b1;
    else begin
      idx = (addr - BASE) / 32'd4;
      if (idx >= 32'd64) err = 1'b1;
    end
    if (sz == 2'd3) err = 1'b1;
    if (sz == 2'd1 && (addr % 32'd2) != 32'd0) err = 1'b1;
    if (sz == 2'd2 && (addr % 32'd4) != 32'd0) err = 1'b1;
    if (err) begin
      idx = 32'd0;
      return;
    end
    w = ref_mem[idx[5:0]];
    k = int'(addr % 32'd4);
    if (sz == 2'd2) begin mask = 32'hFFFF_FFFF; k = 0; end
    else if (sz == 2'd1) begin mask = 32'h0000_FFFF; k = (k / 2) * 2; end
    else mask = 32'h0000_00FF;
    lane = (w >> (8 * k)) & mask;
    if (wr) begin
      nword = (w & ~(mask << (8 * k))) | ((wd & mask) << (8 * k));
      ref_mem[idx[5:0]] = nword;
      nwr = 1;
      lat = (sz == 2'd2) ? 2 : 4;
    end else begin
      rd = lane;
      if (sg && sz != 2'd2 && (lane & ((mask + 32'd1) >> 1)) != 32'd0) rd = lane | ~mask;
      lat = 3;
    end
  endfunction

  task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic hold, input string tag, output logic [31:0] obs_rd);
    logic exp_err;
    logic [31:0] exp_rd, idx, nword;
    int exp_lat, exp_wr, writes, cyc;
    model(wr, sz, sg, addr, wd, exp_err, exp_rd, exp_lat, exp_wr, idx, nword);
    n_req++;
    @(negedge clk);
    check({tag, ":idle_ready"}, {31'd0, bus.req_ready}, 32'd1);
    check({tag, ":idle_addr"}, bus.mem_address, 32'd0);
    check({tag, ":idle_wdata"}, bus.mem_write_data, 32'd0);
    bus.req_write  = wr;
    bus.req_size   = sz;
    bus.req_signed = sg;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.req_valid  = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.req_valid = 1'b0;
    cyc = 0;
    writes = 0;
    do begin
      @(negedge clk);
      cyc++;
      check({tag, ":busy_ready"}, {31'd0, bus.req_ready}, 32'd0);
      if (bus.mem_write_enable) begin
        writes++;
        check({tag, ":wr_addr"}, bus.mem_address, idx);
        check({tag, ":wr_data"}, bus.mem_write_data, nword);
      end
    end while (!bus.resp_valid && cyc < 12);
    check({tag, ":resp_valid"}, {31'd0, bus.resp_valid}, 32'd1);
    check({tag, ":latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, ":error"}, {31'd0, bus.resp_error}, {31'd0, exp_err});
    check({tag, ":rdata"}, bus.resp_rdata, exp_rd);
    check({tag, ":writes"}, 32'(writes), 32'(exp_wr));
    check({tag, ":resp_addr"}, bus.mem_address, 32'd0);
    obs_rd = bus.resp_rdata;
  endtask

  initial begin
    logic [31:0] rd, addr;
    logic [1:0]  sz;
    int          r;
    clk = 1'b0;
    reset = 1'b0;
    tests_run = 0;
    tests_failed = 0;
    n_req = 0;
    accepts = 0;
    for (int i = 0; i < 64; i++) begin
      mem_dev[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_signed = 1'b0; bus.req_addr = 32'd0; bus.req_wdata = 32'd0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
    check("rst_resp_error", {31'd0, bus.resp_error}, 32'd0);
    check("rst_resp_rdata", bus.resp_rdata, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_write_enable}, 32'd0);
    check("rst_mem_addr", bus.mem_address, 32'd0);
    check("rst_mem_wdata", bus.mem_write_data, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'd0, bus.req_ready}, 32'd1);

    // Word store, byte loads, half store
    run_req(1'b1, 2'd2, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF, 1'b0, "sw", rd);
    check("sw_mem2", mem_dev[2], 32'hDEAD_BEEF);
    run_req(1'b0, 2'd0, 1'b1, 32'h1001_000B, 32'd0, 1'b0, "lb", rd);
    check("lb_value", rd, 32'hFFFF_FFDE);
    run_req(1'b0, 2'd0, 1'b0, 32'h1001_000B, 32'd0, 1'b0, "lbu", rd);
    check("lbu_value", rd, 32'h0000_00DE);
    run_req(1'b1, 2'd1, 1'b0, 32'h1001_000A, 32'h0000_1234, 1'b0, "sh", rd);
    check("sh_mem2", mem_dev[2], 32'h1234_BEEF);

    // Error cases
    run_req(1'b0, 2'd2, 1'b0, 32'h1001_0002, 32'd0, 1'b0, "err_lw_mis", rd);
    run_req(1'b0, 2'd1, 1'b0, 32'h1001_0001, 32'd0, 1'b0, "err_lh_mis", rd);
    run_req(1'b1, 2'd2, 1'b0, 32'h1000_FFFC, 32'h1111_1111, 1'b0, "err_sw_low", rd);
    run_req(1'b0, 2'd2, 1'b0, 32'h1001_0100, 32'd0, 1'b0, "err_lw_high", rd);
    run_req(1'b0, 2'd3, 1'b0, 32'h1001_0004, 32'd0, 1'b0, "err_size3", rd);

    // Reset during the write cycle of a half store
    run_req(1'b1, 2'd2, 1'b0, 32'h1001_0008, 32'hDEAD_BEEF, 1'b0, "sw_restore", rd);
    @(negedge clk);
    bus.req_write = 1'b1; bus.req_size = 2'd1; bus.req_signed = 1'b0;
    bus.req_addr = 32'h1001_000A; bus.req_wdata = 32'h0000_5678; bus.req_valid = 1'b1;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rstmid_no_resp", {31'd0, bus.resp_valid}, 32'd0);
    end
    @(negedge clk);
    check("rstmid_we_before", {31'd0, bus.mem_write_enable}, 32'd1);
    reset = 1'b0;
    #1;
    check("rstmid_we_gated", {31'd0, bus.mem_write_enable}, 32'd0);
    @(negedge clk);
    check("rstmid_no_resp2", {31'd0, bus.resp_valid}, 32'd0);
    check("rstmid_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rstmid_mem2", mem_dev[2], 32'hDEAD_BEEF);
    reset = 1'b1;
    n_req++;
    run_req(1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'd0, 1'b0, "lw_after_rst", rd);
    check("lw_after_rst_val", rd, 32'hDEAD_BEEF);

    // Fill memory with random words
    for (int i = 0; i < 64; i++)
      run_req(1'b1, 2'd2, 1'b0, BASE + 32'(i * 4), $urandom, 1'b0, "fill", rd);

    // Back-to-back with req_valid held high
    for (int i = 0; i < 8; i++) begin
      addr = BASE + 32'($urandom_range(0, 255));
      sz = 2'($urandom_range(0, 2));
      if (sz == 2'd2) addr = addr & 32'hFFFF_FFFC;
      if (sz == 2'd1) addr = addr & 32'hFFFF_FFFE;
      run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom, 1'b1, "b2b", rd);
    end
    bus.req_valid = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 150; i++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) addr = BASE - 32'($urandom_range(1, 64));
      else if (r == 1) addr = BASE + 32'd256 + 32'($urandom_range(0, 1023));
      else addr = BASE + 32'($urandom_range(0, 255));
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd2) addr = addr & 32'hFFFF_FFFC;
        if (sz == 2'd1) addr = addr & 32'hFFFF_FFFE;
      end
      run_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), addr, $urandom, 1'b0, "rand", rd);
    end

    @(negedge clk);
    for (int i = 0; i < 64; i++) check("final_mem", mem_dev[i], ref_mem[i]);
    check("accept_count", 32'(accepts), 32'(n_req));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
